// File: rtl/char_writer.sv
// Byte-stream to character-buffer writer: cursor handling, CR/LF/BS decode,
// rotating first-row scrolling with line clear. Optional macro: CHAR_WRITER_AUTOWRAP_EN.
module char_writer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 24,
   parameter int ADDR_W = 11
) (
   input  logic              px_clk,
   input  logic              clr,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [7:0]        buf_din,
   output logic              buf_wen,
   output logic [4:0]        first_row,
   output logic [4:0]        cursor_row,
   output logic [6:0]        cursor_col
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] ROWS_W   = 6'(ROWS);

`ifdef CHAR_WRITER_AUTOWRAP_EN
   localparam logic AUTOWRAP = 1'b1;
`else
   localparam logic AUTOWRAP = 1'b0;
`endif

   state_t            state_r;
   state_t            state_nxt_s;
   logic              rx_ready_s;

   logic [ADDR_W-1:0] buf_addr_r;
   logic [7:0]        buf_din_r;
   logic              buf_wen_r;
   logic [4:0]        first_row_r;
   logic [4:0]        cursor_row_r;
   logic [6:0]        cursor_col_r;
   logic [4:0]        clear_line_r;
   logic [6:0]        clear_col_r;

   logic              accept_s;
   logic              is_print_s;
   logic              is_cr_s;
   logic              is_bs_s;
   logic              is_lf_s;
   logic              at_last_col_s;
   logic              wrap_s;
   logic              newline_s;
   logic              scroll_s;
   logic              clear_done_s;
   logic [5:0]        row_sum_s;
   logic [4:0]        phys_s;
   logic [ADDR_W-1:0] cur_addr_s;
   logic [ADDR_W-1:0] clr_addr_s;

   // Byte decode and buffer address generation
   always_comb begin
      accept_s      = rx_valid && (state_r == ST_IDLE);
      is_print_s    = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
      is_cr_s       = (rx_data == 8'h0D);
      is_bs_s       = (rx_data == 8'h08);
      is_lf_s       = (rx_data == 8'h0A);
      at_last_col_s = (cursor_col_r == LAST_COL);
      wrap_s        = accept_s && is_print_s && at_last_col_s && AUTOWRAP;
      newline_s     = (accept_s && is_lf_s) || wrap_s;
      scroll_s      = newline_s && (cursor_row_r == LAST_ROW);
      clear_done_s  = (state_r == ST_CLEAR) && (clear_col_r == LAST_COL);
      row_sum_s     = {1'b0, first_row_r} + {1'b0, cursor_row_r};
      // Modulo by compare/subtract: ROWS need not be a power of two
      if (row_sum_s >= ROWS_W) begin
         phys_s = 5'(row_sum_s - ROWS_W);
      end else begin
         phys_s = row_sum_s[4:0];
      end
      cur_addr_s = ADDR_W'(phys_s) * ADDR_W'(COLS) + ADDR_W'(cursor_col_r);
      clr_addr_s = ADDR_W'(clear_line_r) * ADDR_W'(COLS) + ADDR_W'(clear_col_r);
   end

   // FSM state register
   always_ff @(posedge px_clk or posedge clr) begin
      if (clr) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (scroll_s) begin
               state_nxt_s = ST_CLEAR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clear_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      rx_ready_s = 1'b0;
      case (state_r)
         ST_IDLE:  rx_ready_s = 1'b1;
         ST_CLEAR: rx_ready_s = 1'b0;
         default:  rx_ready_s = 1'b0;
      endcase
   end

   // Cursor, scroll pointer and buffer write port registers
   always_ff @(posedge px_clk or posedge clr) begin
      if (clr) begin
         buf_addr_r   <= '0;
         buf_din_r    <= 8'h00;
         buf_wen_r    <= 1'b0;
         first_row_r  <= 5'd0;
         cursor_row_r <= 5'd0;
         cursor_col_r <= 7'd0;
         clear_line_r <= 5'd0;
         clear_col_r  <= 7'd0;
      end else if (state_r == ST_CLEAR) begin
         buf_wen_r  <= 1'b1;
         buf_addr_r <= clr_addr_s;
         buf_din_r  <= 8'h20;
         if (clear_done_s) begin
            clear_col_r <= 7'd0;
         end else begin
            clear_col_r <= clear_col_r + 7'd1;
         end
      end else if (accept_s) begin
         if (is_print_s) begin
            buf_wen_r  <= 1'b1;
            buf_addr_r <= cur_addr_s;
            buf_din_r  <= rx_data;
            if (!at_last_col_s) begin
               cursor_col_r <= cursor_col_r + 7'd1;
            end else if (wrap_s) begin
               cursor_col_r <= 7'd0;
            end else begin
               cursor_col_r <= LAST_COL;
            end
         end else begin
            buf_wen_r <= 1'b0;
            if (is_cr_s) begin
               cursor_col_r <= 7'd0;
            end else if (is_bs_s && (cursor_col_r != 7'd0)) begin
               cursor_col_r <= cursor_col_r - 7'd1;
            end else begin
               cursor_col_r <= cursor_col_r;
            end
         end
         // Newline: advance the row, or rotate first_row and blank the exposed line
         if (newline_s) begin
            if (cursor_row_r != LAST_ROW) begin
               cursor_row_r <= cursor_row_r + 5'd1;
            end else begin
               clear_line_r <= first_row_r;
               clear_col_r  <= 7'd0;
               if (first_row_r == LAST_ROW) begin
                  first_row_r <= 5'd0;
               end else begin
                  first_row_r <= first_row_r + 5'd1;
               end
            end
         end else begin
            cursor_row_r <= cursor_row_r;
         end
      end else begin
         buf_wen_r <= 1'b0;
      end
   end

   assign rx_ready   = rx_ready_s;
   assign buf_addr   = buf_addr_r;
   assign buf_din    = buf_din_r;
   assign buf_wen    = buf_wen_r;
   assign first_row  = first_row_r;
   assign cursor_row = cursor_row_r;
   assign cursor_col = cursor_col_r;

endmodule

// File: tb/tb_char_writer.sv
// Self-checking bench for char_writer: vector table, directed scroll/clear/reset
// sequences, and randomized bytes against a screen-level reference model.
module tb_char_writer;

   localparam int COLS   = 80;
   localparam int ROWS   = 24;
   localparam int ADDR_W = 11;

`ifdef CHAR_WRITER_AUTOWRAP_EN
   localparam bit AUTOWRAP = 1'b1;
`else
   localparam bit AUTOWRAP = 1'b0;
`endif

   logic              px_clk;
   logic              clr;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_din;
   logic              buf_wen;
   logic [4:0]        first_row;
   logic [4:0]        cursor_row;
   logic [6:0]        cursor_col;

   int total = 0;
   int bad   = 0;

   logic [8:0] dut_mem [0:2047];
   int         wq_addr [$];
   int         wq_din  [$];

   logic [8:0] m_scr [0:ROWS-1][0:COLS-1];
   int         m_row, m_col, m_first;

   typedef struct {
      logic [7:0] data;
      bit         wr;
      int         addr;
      logic [7:0] din;
      int         row;
      int         col;
   } vec_t;

   vec_t vt [12];

   char_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .px_clk    (px_clk),
      .clr       (clr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .buf_addr  (buf_addr),
      .buf_din   (buf_din),
      .buf_wen   (buf_wen),
      .first_row (first_row),
      .cursor_row(cursor_row),
      .cursor_col(cursor_col)
   );

   initial px_clk = 1'b0;
   always #5 px_clk = ~px_clk;

   // Shadow of the character buffer, built from observed write cycles
   always @(negedge px_clk) begin
      if (clr) begin
         foreach (dut_mem[i]) dut_mem[i] <= 9'h100;
      end else if (buf_wen) begin
         dut_mem[buf_addr] <= {1'b0, buf_din};
         wq_addr.push_back(int'(buf_addr));
         wq_din.push_back(int'(buf_din));
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      clr      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(posedge px_clk); #1;
      @(posedge px_clk); #1;
      clr = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, rx_ready, 1);
      chk({tag, "_wen"}, buf_wen, 0);
      chk({tag, "_addr"}, buf_addr, 0);
      chk({tag, "_din"}, buf_din, 0);
      chk({tag, "_first"}, first_row, 0);
      chk({tag, "_row"}, cursor_row, 0);
      chk({tag, "_col"}, cursor_col, 0);
   endtask

   // Present one byte and return #1 after the edge that accepted it
   task automatic send_byte(input logic [7:0] b);
      int n;
      n        = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 300) begin
         @(posedge px_clk); #1;
         n++;
      end
      chk("ready_wait", rx_ready, 1);
      @(posedge px_clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!rx_ready && n < 300) begin
         @(posedge px_clk); #1;
         n++;
      end
      chk("idle_wait", rx_ready, 1);
      @(negedge px_clk); #1;
   endtask

   task automatic model_step(input logic [7:0] b);
      bit nl;
      nl = 1'b0;
      if (b >= 8'h20 && b <= 8'h7E) begin
         m_scr[m_row][m_col] = {1'b0, b};
         if (m_col < COLS - 1) m_col++;
         else if (AUTOWRAP) begin
            m_col = 0;
            nl    = 1'b1;
         end
      end else if (b == 8'h0D) m_col = 0;
      else if (b == 8'h08) begin
         if (m_col > 0) m_col--;
      end else if (b == 8'h0A) nl = 1'b1;
      if (nl) begin
         if (m_row < ROWS - 1) m_row++;
         else begin
            for (int r = 0; r < ROWS - 1; r++)
               for (int c = 0; c < COLS; c++) m_scr[r][c] = m_scr[r+1][c];
            for (int c = 0; c < COLS; c++) m_scr[ROWS-1][c] = 9'h020;
            m_first = (m_first + 1) % ROWS;
         end
      end
   endtask

   task automatic screen_check();
      int errs, fr, fc, fa, fe;
      errs = 0; fr = 0; fc = 0; fa = 0; fe = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (dut_mem[((m_first + r) % ROWS) * COLS + c] !== m_scr[r][c]) begin
               if (errs == 0) begin
                  fr = r; fc = c;
                  fa = int'(dut_mem[((m_first + r) % ROWS) * COLS + c]);
                  fe = int'(m_scr[r][c]);
               end
               errs++;
            end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL screen: %0d cells differ, first at row %0d col %0d got 0x%0h want 0x%0h",
                  errs, fr, fc, fa, fe);
      end
   endtask

   task automatic check_clear(input string tag, input int base);
      chk({tag, "_count"}, wq_addr.size(), COLS);
      for (int i = 0; i < COLS && i < wq_addr.size(); i++) begin
         chk({tag, "_addr"}, wq_addr[i], base + i);
         chk({tag, "_din"}, wq_din[i], 32'h20);
      end
   endtask

   initial begin
      int lowcnt;
      int r;
      logic [7:0] b;

      vt[0]  = '{8'h41, 1'b1, 0,  8'h41, 0, 1};
      vt[1]  = '{8'h42, 1'b1, 1,  8'h42, 0, 2};
      vt[2]  = '{8'h0D, 1'b0, 0,  8'h00, 0, 0};
      vt[3]  = '{8'h0A, 1'b0, 0,  8'h00, 1, 0};
      vt[4]  = '{8'h43, 1'b1, 80, 8'h43, 1, 1};
      vt[5]  = '{8'h08, 1'b0, 0,  8'h00, 1, 0};
      vt[6]  = '{8'h08, 1'b0, 0,  8'h00, 1, 0};
      vt[7]  = '{8'h7F, 1'b0, 0,  8'h00, 1, 0};
      vt[8]  = '{8'h00, 1'b0, 0,  8'h00, 1, 0};
      vt[9]  = '{8'h1B, 1'b0, 0,  8'h00, 1, 0};
      vt[10] = '{8'h7E, 1'b1, 80, 8'h7E, 1, 1};
      vt[11] = '{8'h20, 1'b1, 81, 8'h20, 1, 2};

      do_reset();
      chk_reset_vals("rst");

      // Table vectors, applied back-to-back
      for (int i = 0; i < 12; i++) begin
         send_byte(vt[i].data);
         chk("vec_wen", buf_wen, vt[i].wr);
         if (vt[i].wr) begin
            chk("vec_addr", buf_addr, vt[i].addr);
            chk("vec_din", buf_din, vt[i].din);
         end
         chk("vec_row", cursor_row, vt[i].row);
         chk("vec_col", cursor_col, vt[i].col);
      end

      // Bottom-row LF scroll and clear of line 0
      do_reset();
      repeat (23) send_byte(8'h0A);
      chk("lf23_row", cursor_row, 23);
      chk("lf23_first", first_row, 0);
      wq_addr.delete();
      wq_din.delete();
      send_byte(8'h0A);
      chk("scroll_first", first_row, 1);
      chk("scroll_row", cursor_row, 23);
      lowcnt = 0;
      while (!rx_ready && lowcnt < 300) begin
         lowcnt++;
         @(posedge px_clk); #1;
      end
      chk("clear_ready_low_cycles", lowcnt, COLS);
      @(negedge px_clk); #1;
      check_clear("clear0", 0);

      // Drive first_row to 23, then scroll across the wrap point
      repeat (22) send_byte(8'h0A);
      wait_idle();
      chk("pre_wrap_first", first_row, 23);
      send_byte(8'h5A);
      chk("z_phys22_addr", buf_addr, 1760);
      send_byte(8'h0D);
      wq_addr.delete();
      wq_din.delete();
      send_byte(8'h0A);
      chk("wrap_first", first_row, 0);
      wait_idle();
      check_clear("clear23", 1840);
      send_byte(8'h5A);
      chk("z_after_wrap_addr", buf_addr, 1840);
      chk("z_after_wrap_din", buf_din, 32'h5A);

      // Full-line fill and end-of-line behaviour
      do_reset();
      for (int i = 0; i < COLS; i++) send_byte(8'(8'h61 + (i % 26)));
      chk("fill_row", cursor_row, AUTOWRAP ? 1 : 0);
      chk("fill_col", cursor_col, AUTOWRAP ? 0 : 79);
      send_byte(8'h21);
      chk("c81_addr", buf_addr, AUTOWRAP ? 80 : 79);
      chk("c81_col", cursor_col, AUTOWRAP ? 1 : 79);

      // Reset in the middle of a clear
      do_reset();
      repeat (23) send_byte(8'h0A);
      send_byte(8'h0A);
      repeat (10) @(posedge px_clk);
      #1;
      chk("mid_clear_wen", buf_wen, 1);
      chk("mid_clear_addr", buf_addr, 9);
      clr = 1'b1;
      #1;
      chk_reset_vals("abort");
      @(posedge px_clk); #1;
      clr = 1'b0;
      wq_addr.delete();
      wq_din.delete();
      repeat (100) @(posedge px_clk);
      #1;
      chk("abort_no_writes", wq_addr.size(), 0);
      chk("abort_ready", rx_ready, 1);

      // Randomized stream against the screen model
      do_reset();
      m_row = 0; m_col = 0; m_first = 0;
      for (int i = 0; i < ROWS; i++)
         for (int c = 0; c < COLS; c++) m_scr[i][c] = 9'h100;
      for (int i = 0; i < 1200; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      b = 8'($urandom_range(32, 126));
         else if (r < 72) b = 8'h0A;
         else if (r < 78) b = 8'h0D;
         else if (r < 86) b = 8'h08;
         else             b = 8'($urandom_range(0, 255));
         send_byte(b);
         model_step(b);
         chk("rnd_row", cursor_row, m_row);
         chk("rnd_col", cursor_col, m_col);
         chk("rnd_first", first_row, m_first);
         if (i % 200 == 199) begin
            wait_idle();
            screen_check();
         end
      end
      wait_idle();
      screen_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
